// File: rtl/vend_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vend_pkg : shared encodings and defaults for the vending mechanism block
// Revision : 1.0
// ---------------------------------------------------------------------------
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MOTOR    = 2'b01,
        SOLENOID = 2'b10,
        HOLD     = 2'b11
    } act_state_t;

    localparam int DEF_DEB_CYC   = 4;
    localparam int DEF_MOTOR_CYC = 8;
    localparam int DEF_SOL_CYC   = 3;

    // One extra bit above clog2 so a counter loaded with the largest length never wraps.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vend_debounce : 2-flop synchronizer, debounce filter and rising-edge pulse
// Revision : 1.0
// ---------------------------------------------------------------------------
module vend_debounce
    import vend_pkg::*;
#(
    parameter int DEB_CYC = DEF_DEB_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int            CW       = $clog2(DEB_CYC) + 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= 1'b0;
            if (s2 != level) begin
                // The new level must persist for DEB_CYC consecutive samples.
                if (cnt == DEB_LAST) begin
                    level <= s2;
                    cnt   <= '0;
                    rise  <= s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vend_mech_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vend_mech_ctrl : input conditioning, event arbitration and actuator timing
// Revision : 1.0
// ---------------------------------------------------------------------------
module vend_mech_ctrl
    import vend_pkg::*;
#(
    parameter int DEB_CYC   = DEF_DEB_CYC,
    parameter int MOTOR_CYC = DEF_MOTOR_CYC,
    parameter int SOL_CYC   = DEF_SOL_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic coin50_raw,
    input  logic coin100_raw,
    input  logic cancel_raw,
    input  logic dispense,
    input  logic money_return,
    input  logic insert_coin,
    output logic fifty,
    output logic dollar,
    output logic cancel,
    output logic motor_on,
    output logic solenoid_on,
    output logic coin_lamp,
    output logic vend_done,
    output logic busy
);

    localparam int            CW         = cnt_width(MOTOR_CYC, SOL_CYC, DEB_CYC);
    localparam logic [CW-1:0] MOTOR_LOAD = CW'(MOTOR_CYC - 1);
    localparam logic [CW-1:0] SOL_LOAD   = CW'(SOL_CYC - 1);

    logic [2:0] raw_vec;
    logic [2:0] level_vec;
    logic [2:0] rise_vec;

    act_state_t    state;
    logic [CW-1:0] cnt;
    logic          pending_return;

    assign raw_vec = {cancel_raw, coin100_raw, coin50_raw};

    generate
        for (genvar i = 0; i < 3; i++) begin : g_deb
            vend_debounce #(
                .DEB_CYC (DEB_CYC)
            ) u_deb (
                .clk   (clk),
                .rst   (rst),
                .raw   (raw_vec[i]),
                .level (level_vec[i]),
                .rise  (rise_vec[i])
            );
        end
    endgenerate

    // Coins arriving during a mechanical cycle are dropped; cancel always passes.
    assign cancel = rise_vec[2];
    assign dollar = rise_vec[1] & ~rise_vec[2] & ~busy;
    assign fifty  = rise_vec[0] & ~rise_vec[1] & ~rise_vec[2] & ~busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            pending_return <= 1'b0;
            motor_on       <= 1'b0;
            solenoid_on    <= 1'b0;
            vend_done      <= 1'b0;
            busy           <= 1'b0;
            coin_lamp      <= 1'b0;
        end else begin
            coin_lamp <= insert_coin;
            vend_done <= 1'b0;
            if (money_return && (state != IDLE)) begin
                pending_return <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (dispense) begin
                        state    <= MOTOR;
                        cnt      <= MOTOR_LOAD;
                        motor_on <= 1'b1;
                        busy     <= 1'b1;
                        if (money_return) begin
                            pending_return <= 1'b1;
                        end
                    end else if (money_return || pending_return) begin
                        state          <= SOLENOID;
                        cnt            <= SOL_LOAD;
                        solenoid_on    <= 1'b1;
                        busy           <= 1'b1;
                        pending_return <= 1'b0;
                    end
                end
                MOTOR: begin
                    if (cnt == '0) begin
                        state     <= HOLD;
                        motor_on  <= 1'b0;
                        vend_done <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SOLENOID: begin
                    if (cnt == '0) begin
                        state       <= HOLD;
                        solenoid_on <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    // Wait for dispense to drop so a held request vends only once.
                    if (!dispense) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vend_mech_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vend_mech_ctrl : scoreboard bench with randomized coin/vend/refund traffic
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_vend_mech_ctrl;
    import vend_pkg::*;

    localparam int DEB = 4;
    localparam int M   = 8;
    localparam int S   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic coin50_raw = 1'b0, coin100_raw = 1'b0, cancel_raw = 1'b0;
    logic dispense = 1'b0, money_return = 1'b0, insert_coin = 1'b0;
    logic fifty, dollar, cancel, motor_on, solenoid_on, coin_lamp, vend_done, busy;

    vend_mech_ctrl #(
        .DEB_CYC   (DEB),
        .MOTOR_CYC (M),
        .SOL_CYC   (S)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coin50_raw   (coin50_raw),
        .coin100_raw  (coin100_raw),
        .cancel_raw   (cancel_raw),
        .dispense     (dispense),
        .money_return (money_return),
        .insert_coin  (insert_coin),
        .fifty        (fifty),
        .dollar       (dollar),
        .cancel       (cancel),
        .motor_on     (motor_on),
        .solenoid_on  (solenoid_on),
        .coin_lamp    (coin_lamp),
        .vend_done    (vend_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int kind; int at; } ev_t;
    typedef struct { int at; int len; } pulse_t;
    ev_t    ev_q[$];
    pulse_t mot_q[$];
    pulse_t sol_q[$];
    int     vd_q[$];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    endtask

    // Event monitor: kinds 0=fifty 1=dollar 2=cancel
    ev_t e_mon;
    int  k_mon;
    always @(negedge clk) begin
        if (fifty || dollar || cancel) begin
            chk("event_onehot", int'(fifty) + int'(dollar) + int'(cancel), 1);
            k_mon = cancel ? 2 : (dollar ? 1 : 0);
            if (ev_q.size() == 0) begin
                chk("event_unexpected_kind", k_mon, -1);
            end else begin
                e_mon = ev_q.pop_front();
                chk("event_kind", k_mon, e_mon.kind);
                chk("event_cycle", cyc, e_mon.at);
            end
        end
    end

    // Actuator monitor
    logic   pm = 1'b0, ps = 1'b0;
    int     mlen = 0, slen = 0, vd_exp;
    pulse_t pm_exp, ps_exp;
    logic   lamp_exp = 1'b0;
    always @(posedge clk) lamp_exp <= rst ? 1'b0 : insert_coin;

    always @(negedge clk) begin
        chk("coin_lamp", int'(coin_lamp), int'(lamp_exp));
        if (motor_on && !pm) begin
            if (mot_q.size() == 0) begin
                chk("motor_unexpected", 1, 0);
                pm_exp.len = -1;
            end else begin
                pm_exp = mot_q.pop_front();
                chk("motor_start", cyc, pm_exp.at);
            end
            mlen = 0;
        end
        if (motor_on) mlen++;
        if (!motor_on && pm && pm_exp.len >= 0) chk("motor_len", mlen, pm_exp.len);
        pm = motor_on;

        if (solenoid_on && !ps) begin
            if (sol_q.size() == 0) begin
                chk("solenoid_unexpected", 1, 0);
                ps_exp.len = -1;
            end else begin
                ps_exp = sol_q.pop_front();
                chk("solenoid_start", cyc, ps_exp.at);
            end
            slen = 0;
        end
        if (solenoid_on) slen++;
        if (!solenoid_on && ps && ps_exp.len >= 0) chk("solenoid_len", slen, ps_exp.len);
        ps = solenoid_on;

        if (vend_done) begin
            if (vd_q.size() == 0) begin
                chk("vend_done_unexpected", 1, 0);
            end else begin
                vd_exp = vd_q.pop_front();
                chk("vend_done_cycle", cyc, vd_exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        insert_coin = 1'($urandom_range(0, 1));
    endtask

    task automatic set_raw(input int kind, input logic v);
        case (kind)
            0:       coin50_raw  = v;
            1:       coin100_raw = v;
            default: cancel_raw  = v;
        endcase
    endtask

    // Raw input held h cycles from now; a held input qualifies DEB+2 cycles later.
    task automatic coin(input int kind, input int h, input bit glitch);
        ev_t e;
        if (!glitch) begin
            e.kind = kind;
            e.at   = cyc + 2 + DEB;
            ev_q.push_back(e);
        end
        set_raw(kind, 1'b1);
        repeat (h) step();
        set_raw(kind, 1'b0);
        repeat (DEB + 4) step();
    endtask

    task automatic coin_pair();
        ev_t e;
        e.kind = 2;
        e.at   = cyc + 2 + DEB;
        ev_q.push_back(e);
        coin100_raw = 1'b1;
        cancel_raw  = 1'b1;
        repeat (DEB + 4) step();
        coin100_raw = 1'b0;
        cancel_raw  = 1'b0;
        repeat (DEB + 4) step();
    endtask

    // dispense held d cycles; optional 1-cycle refund request at offset r;
    // optional raw input of kind ck pressed while the motor runs.
    task automatic vend(input int d, input bit ret, input int r, input bit coin_on, input int ck);
        int n, e_idle, fin;
        pulse_t p;
        ev_t ev;
        n = cyc;
        p.at = n + 1; p.len = M;
        mot_q.push_back(p);
        vd_q.push_back(n + M + 1);
        e_idle = (d + 1 > M + 2) ? n + d + 1 : n + M + 2;
        if (ret) begin
            p.at = e_idle + 1; p.len = S;
            sol_q.push_back(p);
            fin = e_idle + S + 2;
        end else begin
            fin = e_idle;
        end
        if (coin_on && ck == 2) begin
            ev.kind = 2; ev.at = n + 3 + DEB;
            ev_q.push_back(ev);
        end
        for (int t = 0; t < fin - n; t++) begin
            dispense     = (t < d);
            money_return = ret && (t == r);
            if (coin_on) set_raw(ck, (t >= 1) && (t < DEB + 3));
            if (t == 1) chk("busy_during_vend", int'(busy), 1);
            if (t == fin - n - 1) chk("busy_before_idle", int'(busy), 1);
            step();
        end
        dispense     = 1'b0;
        money_return = 1'b0;
        if (coin_on) set_raw(ck, 1'b0);
        chk("busy_idle_after_vend", int'(busy), 0);
        repeat (DEB + 4) step();
    endtask

    task automatic refund();
        pulse_t p;
        p.at = cyc + 1; p.len = S;
        sol_q.push_back(p);
        money_return = 1'b1;
        step();
        money_return = 1'b0;
        repeat (S + 1) step();
        chk("busy_idle_after_refund", int'(busy), 0);
    endtask

    task automatic reset_mid_motor();
        pulse_t p;
        p.at = cyc + 1; p.len = 4;
        mot_q.push_back(p);
        dispense = 1'b1;
        step();
        dispense = 1'b0;
        step();
        money_return = 1'b1;
        step();
        money_return = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_motor_on", int'(motor_on), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_vend_done", int'(vend_done), 0);
        repeat (20) step();
        chk("rst_no_pending_refund", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        chk("reset_fifty", int'(fifty), 0);
        chk("reset_dollar", int'(dollar), 0);
        chk("reset_cancel", int'(cancel), 0);
        chk("reset_motor_on", int'(motor_on), 0);
        chk("reset_solenoid_on", int'(solenoid_on), 0);
        chk("reset_vend_done", int'(vend_done), 0);
        chk("reset_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (2) step();

        coin(0, 20, 1'b0);
        coin(1, 3, 1'b1);
        coin_pair();
        vend(30, 1'b0, 0, 1'b0, 0);
        vend(1, 1'b1, 4, 1'b0, 0);
        vend(2, 1'b1, 0, 1'b0, 0);
        vend(3, 1'b0, 0, 1'b1, 0);
        coin(0, DEB + 2, 1'b0);
        vend(4, 1'b0, 0, 1'b1, 2);
        refund();

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    coin($urandom_range(0, 2), $urandom_range(DEB, DEB + 6), 1'b0);
                2:       coin($urandom_range(0, 2), $urandom_range(1, DEB - 1), 1'b1);
                3, 4:    vend($urandom_range(1, 20), 1'($urandom_range(0, 1)), $urandom_range(0, M + 1),
                              1'($urandom_range(0, 1)), $urandom_range(0, 2));
                default: refund();
            endcase
        end

        reset_mid_motor();
        repeat (4) step();

        chk("events_outstanding", ev_q.size(), 0);
        chk("motor_outstanding", mot_q.size(), 0);
        chk("solenoid_outstanding", sol_q.size(), 0);
        chk("vend_done_outstanding", vd_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
